// File: rtl/rdm_pkg.sv
// rdm_pkg: shared state enum, default widths and buffer-entry layout for the de-matching pop sequencer.
// Ports: none (package).
package rdm_pkg;
    localparam int RDM_DATA_W = 256;
    localparam int RDM_AMT_W  = 5;
    localparam int RDM_LEN_W  = 16;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} rdm_seq_state_t;
    typedef struct packed {
        logic [RDM_DATA_W-1:0] data;
        logic [RDM_AMT_W-1:0]  bytes_m1;
        logic                  last;
    } rdm_buf_entry_t;
endpackage

// File: rtl/rdm_skid_buf2.sv
// rdm_skid_buf2: 2-entry FIFO with registered occupancy, push/pop and synchronous flush.
// Ports: clk/rst clock and async reset; flush empties the buffer; push/wdata write side;
//        pop/rdata/valid read side (rdata is the head entry); occ current occupancy 0..2.
module rdm_skid_buf2
    import rdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         valid,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    logic         do_pop;
    logic         do_push;
    assign valid   = occ != 2'd0;
    assign rdata   = mem[rp];
    assign do_pop  = pop & valid;
    // a full buffer only accepts a write when the head leaves in the same cycle
    assign do_push = push & ((occ != 2'd2) | do_pop);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= ~wp;
            end
            if (do_pop) rp <= ~rp;
            occ <= occ + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/rdm_pop_sequencer.sv
// rdm_pop_sequencer: drains a job of N bytes from the parallel FIFO in bounded pops and streams each chunk downstream.
// Ports: i_core_clk/i_rx_rst clock and async reset; i_job_valid/o_job_ready/i_job_len_m1/i_chunk_max_m1 job request;
//        i_abort job termination; o_pop_permit/o_pop_amount/i_pop_enable/i_pop_data FIFO read port;
//        o_out_valid/i_out_ready/o_out_data/o_out_bytes_m1/o_out_last chunk stream; o_busy/o_done/o_err status.
module rdm_pop_sequencer
    import rdm_pkg::*;
#(
    parameter int DATA_W = RDM_DATA_W,
    parameter int AMT_W  = RDM_AMT_W,
    parameter int LEN_W  = RDM_LEN_W
) (
    input  logic              i_core_clk,
    input  logic              i_rx_rst,
    input  logic              i_job_valid,
    output logic              o_job_ready,
    input  logic [LEN_W-1:0]  i_job_len_m1,
    input  logic [AMT_W-1:0]  i_chunk_max_m1,
    input  logic              i_abort,
    output logic              o_pop_permit,
    output logic [AMT_W-1:0]  o_pop_amount,
    input  logic              i_pop_enable,
    input  logic [DATA_W-1:0] i_pop_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [AMT_W-1:0]  o_out_bytes_m1,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int BW = DATA_W + AMT_W + 1;

    rdm_seq_state_t state;
    rdm_seq_state_t state_nx;
    logic [LEN_W:0]   rem_m1;
    logic             rem_vld;
    logic [AMT_W-1:0] chunk_m1;
    logic [1:0]       occ;
    logic [BW-1:0]    head;
    logic             accept;
    logic             abort_act;
    logic             push;
    logic             fire;
    logic             last;
    logic             proto_err;

    assign o_job_ready  = state == IDLE;
    assign o_busy       = state != IDLE;
    assign o_done       = state == DONE;
    assign accept       = i_job_valid & o_job_ready;
    assign abort_act    = i_abort & (state != IDLE);
    assign last         = rem_m1 <= (LEN_W+1)'(chunk_m1);
    // permit and amount depend on registers only, never on the pop strobe or downstream ready
    assign o_pop_permit = (state == RUN) & rem_vld & (occ != 2'd2);
    assign o_pop_amount = (state == RUN) ? (last ? rem_m1[AMT_W-1:0] : chunk_m1) : '0;
    assign push         = i_pop_enable & o_pop_permit & ~i_abort;
    assign proto_err    = i_pop_enable & ~o_pop_permit;
    assign fire         = o_out_valid & i_out_ready;
    assign {o_out_data, o_out_bytes_m1, o_out_last} = head;

    rdm_skid_buf2 #(.W(BW)) u_buf (
        .clk   (i_core_clk),
        .rst   (i_rx_rst),
        .flush (abort_act),
        .push  (push),
        .wdata ({i_pop_data, o_pop_amount, last}),
        .pop   (fire),
        .rdata (head),
        .valid (o_out_valid),
        .occ   (occ)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = (push & last) ? FLUSH : RUN;
            // leave on the edge that drains the final beat so DONE follows it directly
            FLUSH:   state_nx = ((occ == 2'd0) | ((occ == 2'd1) & fire)) ? DONE : FLUSH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort_act) state_nx = IDLE;
    end

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            rem_m1   <= '0;
            rem_vld  <= 1'b0;
            chunk_m1 <= '0;
        end else if (abort_act) begin
            rem_m1   <= '0;
            rem_vld  <= 1'b0;
        end else if (accept) begin
            rem_m1   <= {1'b0, i_job_len_m1};
            rem_vld  <= 1'b1;
            chunk_m1 <= i_chunk_max_m1;
        end else if (push) begin
            if (last) rem_vld <= 1'b0;
            else      rem_m1  <= rem_m1 - (LEN_W+1)'(chunk_m1) - (LEN_W+1)'(1);
        end
    end

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) o_err <= 1'b0;
        else          o_err <= accept ? 1'b0 : (o_err | proto_err);
    end
endmodule

// File: tb/tb_rdm_pop_sequencer.sv
// tb_rdm_pop_sequencer: randomized and directed bench with a byte-count/queue reference model.
// Ports: none (testbench top).
module tb_rdm_pop_sequencer;
    import rdm_pkg::*;
    localparam int DW = RDM_DATA_W;
    localparam int AW = RDM_AMT_W;
    localparam int LW = RDM_LEN_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_job_valid = 1'b0;
    logic          o_job_ready;
    logic [LW-1:0] i_job_len_m1 = '0;
    logic [AW-1:0] i_chunk_max_m1 = '0;
    logic          i_abort = 1'b0;
    logic          o_pop_permit;
    logic [AW-1:0] o_pop_amount;
    logic          i_pop_enable = 1'b0;
    logic [DW-1:0] i_pop_data = '0;
    logic          o_out_valid;
    logic          i_out_ready = 1'b0;
    logic [DW-1:0] o_out_data;
    logic [AW-1:0] o_out_bytes_m1;
    logic          o_out_last;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    rdm_pop_sequencer dut (
        .i_core_clk     (clk),
        .i_rx_rst       (rst),
        .i_job_valid    (i_job_valid),
        .o_job_ready    (o_job_ready),
        .i_job_len_m1   (i_job_len_m1),
        .i_chunk_max_m1 (i_chunk_max_m1),
        .i_abort        (i_abort),
        .o_pop_permit   (o_pop_permit),
        .o_pop_amount   (o_pop_amount),
        .i_pop_enable   (i_pop_enable),
        .i_pop_data     (i_pop_data),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_out_data     (o_out_data),
        .o_out_bytes_m1 (o_out_bytes_m1),
        .o_out_last     (o_out_last),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_pct = 100;
    int av_pct = 100;
    bit force_pop = 1'b0;

    typedef struct {
        logic [DW-1:0] d;
        int            b;
        bit            l;
    } beat_t;

    bit    m_act = 1'b0;
    bit    m_done = 1'b0;
    bit    m_err = 1'b0;
    int    m_amts[$];
    beat_t m_pend[$];

    int log_amt[$];
    int log_cyc[$];
    int log_last[$];
    int log_bytes[$];
    int log_fire_cyc[$];
    int log_done_cyc[$];
    int done_count = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        logic [DW-1:0] m;
        #1;
        m = '1;
        m = m >> (8 * (DW/8 - 1 - int'(o_pop_amount)));
        i_out_ready  = $urandom_range(99) < rdy_pct;
        i_pop_enable = force_pop || (o_pop_permit && ($urandom_range(99) < av_pct));
        i_pop_data   = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()} & m;
    end

    always @(negedge clk) begin
        bit    perm;
        bit    fire;
        beat_t bt;
        int    rem;
        int    a;
        cyc++;
        if (rst) begin
            chk("rst_job_ready", o_job_ready, 1);
            chk("rst_pop_permit", o_pop_permit, 0);
            chk("rst_pop_amount", o_pop_amount, 0);
            chk("rst_out_valid", o_out_valid, 0);
            chk("rst_out_data", o_out_data, 0);
            chk("rst_out_bytes", o_out_bytes_m1, 0);
            chk("rst_out_last", o_out_last, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_err", o_err, 0);
            m_act = 0;
            m_done = 0;
            m_err = 0;
            m_amts.delete();
            m_pend.delete();
        end else begin
            perm = m_act && m_amts.size() > 0 && m_pend.size() < 2;
            chk("job_ready", o_job_ready, !m_act);
            chk("busy", o_busy, m_act);
            chk("done", o_done, m_done);
            chk("err", o_err, m_err);
            chk("pop_permit", o_pop_permit, perm);
            if (perm) chk("pop_amount", o_pop_amount, m_amts[0]);
            chk("out_valid", o_out_valid, m_pend.size() > 0);
            if (m_pend.size() > 0) begin
                chk("out_data", o_out_data, m_pend[0].d);
                chk("out_bytes", o_out_bytes_m1, m_pend[0].b);
                chk("out_last", o_out_last, m_pend[0].l);
            end
            if (i_pop_enable && o_pop_permit && !i_abort) begin
                log_amt.push_back(int'(o_pop_amount));
                log_cyc.push_back(cyc);
            end
            if (o_out_valid && i_out_ready) begin
                log_last.push_back(int'(o_out_last));
                log_bytes.push_back(int'(o_out_bytes_m1));
                log_fire_cyc.push_back(cyc);
            end
            if (o_done) begin
                done_count++;
                log_done_cyc.push_back(cyc);
            end
            fire = m_pend.size() > 0 && i_out_ready;
            if (i_pop_enable && !perm) m_err = 1;
            if (m_act && i_abort) begin
                m_act = 0;
                m_done = 0;
                m_amts.delete();
                m_pend.delete();
            end else if (m_done) begin
                m_done = 0;
                m_act = 0;
            end else if (!m_act) begin
                if (i_job_valid) begin
                    m_act = 1;
                    m_err = 0;
                    rem = int'(i_job_len_m1) + 1;
                    while (rem > 0) begin
                        a = (rem < int'(i_chunk_max_m1) + 1) ? rem : int'(i_chunk_max_m1) + 1;
                        m_amts.push_back(a - 1);
                        rem -= a;
                    end
                end
            end else begin
                if (fire) void'(m_pend.pop_front());
                if (i_pop_enable && perm) begin
                    bt.d = i_pop_data;
                    bt.b = m_amts.pop_front();
                    bt.l = m_amts.size() == 0;
                    m_pend.push_back(bt);
                end
                if (fire && m_pend.size() == 0 && m_amts.size() == 0) m_done = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!o_job_ready && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", o_job_ready, 1);
    endtask

    task automatic submit(input int len_m1, input int ch_m1);
        wait_idle(40000);
        i_job_valid    = 1'b1;
        i_job_len_m1   = LW'(len_m1);
        i_chunk_max_m1 = AW'(ch_m1);
        step();
        i_job_valid    = 1'b0;
        i_chunk_max_m1 = AW'($urandom());
    endtask

    task automatic clear_logs();
        log_amt.delete();
        log_cyc.delete();
        log_last.delete();
        log_bytes.delete();
        log_fire_cyc.delete();
        log_done_cyc.delete();
        done_count = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        repeat (3) step();
        rst = 1'b0;
        step();

        clear_logs();
        rdy_pct = 100;
        av_pct = 100;
        submit(99, 31);
        chk("t1_permit_after_accept", o_pop_permit, 1);
        wait_idle(200);
        chk("t1_npops", log_amt.size(), 4);
        if (log_amt.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t1_amount", log_amt[i], (i < 3) ? 31 : 3);
            chk("t1_no_bubbles", log_cyc[3] - log_cyc[0], 3);
        end
        chk("t1_nbeats", log_last.size(), 4);
        if (log_last.size() == 4)
            for (int i = 0; i < 4; i++) chk("t1_last", log_last[i], i == 3);
        chk("t1_done_once", done_count, 1);
        if (done_count == 1 && log_fire_cyc.size() == 4)
            chk("t1_done_latency", log_done_cyc[0] - log_fire_cyc[3], 1);

        clear_logs();
        submit(0, $urandom_range(31));
        wait_idle(50);
        chk("t2_npops", log_amt.size(), 1);
        if (log_amt.size() == 1) chk("t2_amount", log_amt[0], 0);
        chk("t2_nbeats", log_last.size(), 1);
        if (log_last.size() == 1) begin
            chk("t2_last", log_last[0], 1);
            chk("t2_bytes", log_bytes[0], 0);
        end
        chk("t2_done_once", done_count, 1);

        clear_logs();
        rdy_pct = 0;
        submit(127, 31);
        repeat (10) step();
        chk("t3_pops_in_stall", log_amt.size(), 2);
        chk("t3_permit_stalled", o_pop_permit, 0);
        force_pop = 1'b1;
        step();
        force_pop = 1'b0;
        step();
        chk("t3_err_set", o_err, 1);
        chk("t3_pops_after_err", log_amt.size(), 2);
        repeat (3) step();
        chk("t3_err_sticky", o_err, 1);
        rdy_pct = 100;
        wait_idle(100);
        chk("t3_npops", log_amt.size(), 4);
        chk("t3_nbeats", log_bytes.size(), 4);
        chk("t3_done_once", done_count, 1);

        clear_logs();
        submit(99, 31);
        chk("t4_err_cleared", o_err, 0);
        n = 0;
        while (log_amt.size() < 2 && n < 50) begin
            step();
            n++;
        end
        chk("t4_two_pops", log_amt.size(), 2);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("t4_abort_ready", o_job_ready, 1);
        chk("t4_abort_valid", o_out_valid, 0);
        chk("t4_abort_busy", o_busy, 0);
        repeat (5) step();
        chk("t4_abort_no_done", done_count, 0);
        clear_logs();
        submit(63, 15);
        wait_idle(100);
        chk("t4_npops", log_amt.size(), 4);
        if (log_amt.size() == 4)
            for (int i = 0; i < 4; i++) chk("t4_amount", log_amt[i], 15);
        chk("t4_done_once", done_count, 1);

        clear_logs();
        rdy_pct = 50;
        submit(99, 31);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", o_job_ready, 1);
        chk("t5_rst_permit", o_pop_permit, 0);
        chk("t5_rst_amount", o_pop_amount, 0);
        chk("t5_rst_valid", o_out_valid, 0);
        chk("t5_rst_data", o_out_data, 0);
        chk("t5_rst_last", o_out_last, 0);
        chk("t5_rst_busy", o_busy, 0);
        chk("t5_rst_err", o_err, 0);
        step();
        rst = 1'b0;
        step();
        clear_logs();
        rdy_pct = 100;
        submit(39, 7);
        wait_idle(100);
        chk("t5_npops", log_amt.size(), 5);
        if (log_amt.size() == 5)
            for (int i = 0; i < 5; i++) chk("t5_amount", log_amt[i], 7);
        chk("t5_done_once", done_count, 1);

        clear_logs();
        submit(4, 0);
        wait_idle(100);
        chk("t6_chunk1_npops", log_amt.size(), 5);
        if (log_amt.size() == 5) chk("t6_chunk1_amount", log_amt[4], 0);

        clear_logs();
        submit(65535, 31);
        wait_idle(5000);
        chk("t6_max_npops", log_amt.size(), 2048);
        if (log_amt.size() == 2048) chk("t6_max_final", log_amt[2047], 31);
        chk("t6_max_done", done_count, 1);

        for (int j = 0; j < 40; j++) begin
            rdy_pct = $urandom_range(20, 100);
            av_pct  = $urandom_range(20, 100);
            len = ($urandom_range(9) == 0) ? $urandom_range(1500) : $urandom_range(150);
            submit(len, $urandom_range(31));
            n = 0;
            while (!o_job_ready && n < 20000) begin
                if ($urandom_range(199) == 0) i_abort = 1'b1;
                if ($urandom_range(99) == 0) force_pop = 1'b1;
                step();
                i_abort = 1'b0;
                force_pop = 1'b0;
                n++;
            end
            chk("rand_job_timeout", o_job_ready, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
